// File: rtl/vend_ctrl_multi.sv
// Vending controller: coin credit, per-item stock, programmable prices,
// timed indicator lamps and coin-by-coin change over a valid/ready handshake.
module vend_ctrl_multi #(
    parameter int NUM_ITEMS   = 4,
    parameter int CREDIT_W    = 12,
    parameter int PRICE_W     = 8,
    parameter int STOCK_W     = 6,
    parameter int STOCK_INIT  = 15,
    parameter int COIN0       = 5,
    parameter int COIN1       = 10,
    parameter int COIN2       = 50,
    parameter int HOLD_CYCLES = 120_000_000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [2:0]                   coin_in,
    input  logic [NUM_ITEMS-1:0]         buy_req,
    input  logic                         refund,
    input  logic                         restock,
    input  logic [NUM_ITEMS*PRICE_W-1:0] price_bus,
    output logic [CREDIT_W-1:0]          credit,
    output logic [NUM_ITEMS-1:0]         stock_empty,
    output logic                         out_take,
    output logic                         out_less,
    output logic                         out_money,
    output logic                         out_empty,
    output logic [2:0]                   vend_item,
    output logic                         vend_pulse,
    output logic                         coin_rej,
    output logic [2:0]                   coin_out,
    output logic                         coin_out_valid,
    input  logic                         coin_out_ready
);

    // state  | meaning
    // IDLE   | accepting coins, refund, buy and restock requests
    // CHANGE | paying out credit one coin at a time
    // HOLD   | one lamp lit, waiting for the hold timer to expire
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CHANGE = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int SW = CREDIT_W + 2;
    localparam logic [CREDIT_W-1:0] C0 = CREDIT_W'(COIN0);
    localparam logic [CREDIT_W-1:0] C1 = CREDIT_W'(COIN1);
    localparam logic [CREDIT_W-1:0] C2 = CREDIT_W'(COIN2);
    localparam logic [SW-1:0] CREDIT_MAX = {2'b00, {CREDIT_W{1'b1}}};

    logic [1:0]          state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [STOCK_W-1:0]  stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]  stock_d [NUM_ITEMS];
    logic                take_q, take_d, less_q, less_d;
    logic                money_q, money_d, empty_q, empty_d;
    logic [2:0]          item_q, item_d;
    logic                vpulse_q, vpulse_d, rej_q, rej_d;
    logic [2:0]          cout_q, cout_d;
    logic                cvalid_q, cvalid_d;
    logic [HW-1:0]       hold_q, hold_d;

    logic [SW-1:0]       coin_sum, total;
    logic [CREDIT_W-1:0] base, paid, sel_price;
    logic [STOCK_W-1:0]  sel_stock;
    int                  sel;

    function automatic logic [2:0] pick_coin(input logic [CREDIT_W-1:0] c);
        if (c >= C2) return 3'b100;
        if (c >= C1) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_val(input logic [2:0] oh);
        case (oh)
            3'b100:  return C2;
            3'b010:  return C1;
            3'b001:  return C0;
            default: return '0;
        endcase
    endfunction

    always_comb begin
        coin_sum = '0;
        if (coin_in[0]) coin_sum = coin_sum + SW'(COIN0);
        if (coin_in[1]) coin_sum = coin_sum + SW'(COIN1);
        if (coin_in[2]) coin_sum = coin_sum + SW'(COIN2);
    end

    // Lowest requested index wins when several buy bits are set.
    always_comb begin
        sel       = 0;
        sel_price = '0;
        sel_stock = '0;
        for (int k = NUM_ITEMS - 1; k >= 0; k--) begin
            if (buy_req[k]) sel = k;
        end
        for (int k = 0; k < NUM_ITEMS; k++) begin
            if (k == sel) begin
                sel_price = CREDIT_W'(price_bus[k*PRICE_W +: PRICE_W]);
                sel_stock = stock_q[k];
            end
        end
    end

    assign paid = credit_q - coin_val(cout_q);

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        stock_d  = stock_q;
        take_d   = take_q;
        less_d   = less_q;
        money_d  = money_q;
        empty_d  = empty_q;
        item_d   = item_q;
        vpulse_d = 1'b0;
        rej_d    = 1'b0;
        cout_d   = cout_q;
        cvalid_d = cvalid_q;
        hold_d   = hold_q;
        base     = credit_q;
        total    = '0;

        case (state_q)
            ST_IDLE: begin
                if (refund) begin
                    if (credit_q == '0) begin
                        state_d = ST_HOLD;
                        money_d = 1'b1;
                        hold_d  = HW'(HOLD_CYCLES);
                    end else begin
                        state_d = ST_CHANGE;
                    end
                end else if (|buy_req) begin
                    state_d = ST_HOLD;
                    hold_d  = HW'(HOLD_CYCLES);
                    if (sel_stock == '0) begin
                        empty_d = 1'b1;
                    end else if (credit_q < sel_price) begin
                        less_d = 1'b1;
                    end else begin
                        base     = credit_q - sel_price;
                        item_d   = 3'(sel);
                        vpulse_d = 1'b1;
                        take_d   = 1'b1;
                        for (int k = 0; k < NUM_ITEMS; k++) begin
                            if (k == sel) stock_d[k] = stock_q[k] - STOCK_W'(1);
                        end
                    end
                end else if (restock) begin
                    for (int k = 0; k < NUM_ITEMS; k++) stock_d[k] = STOCK_W'(STOCK_INIT);
                end
            end
            ST_CHANGE: begin
                if (!cvalid_q) begin
                    if (credit_q >= C0) begin
                        cvalid_d = 1'b1;
                        cout_d   = pick_coin(credit_q);
                    end else begin
                        state_d = ST_HOLD;
                        money_d = 1'b1;
                        hold_d  = HW'(HOLD_CYCLES);
                    end
                end else if (coin_out_ready) begin
                    credit_d = paid;
                    if (paid >= C0) begin
                        cout_d = pick_coin(paid);
                    end else begin
                        cvalid_d = 1'b0;
                        cout_d   = 3'b000;
                        state_d  = ST_HOLD;
                        money_d  = 1'b1;
                        hold_d   = HW'(HOLD_CYCLES);
                    end
                end
            end
            ST_HOLD: begin
                if (hold_q == HW'(1)) begin
                    state_d = ST_IDLE;
                    take_d  = 1'b0;
                    less_d  = 1'b0;
                    money_d = 1'b0;
                    empty_d = 1'b0;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Coins are added after any vend deduction of the same cycle.
        if (state_q != ST_CHANGE) begin
            total = {2'b00, base} + coin_sum;
            if (total > CREDIT_MAX) begin
                rej_d    = 1'b1;
                credit_d = base;
            end else begin
                credit_d = total[CREDIT_W-1:0];
            end
        end else if (|coin_in) begin
            rej_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            credit_q <= '0;
            for (int k = 0; k < NUM_ITEMS; k++) stock_q[k] <= STOCK_W'(STOCK_INIT);
            take_q   <= 1'b0;
            less_q   <= 1'b0;
            money_q  <= 1'b0;
            empty_q  <= 1'b0;
            item_q   <= 3'd0;
            vpulse_q <= 1'b0;
            rej_q    <= 1'b0;
            cout_q   <= 3'b000;
            cvalid_q <= 1'b0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            credit_q <= credit_d;
            stock_q  <= stock_d;
            take_q   <= take_d;
            less_q   <= less_d;
            money_q  <= money_d;
            empty_q  <= empty_d;
            item_q   <= item_d;
            vpulse_q <= vpulse_d;
            rej_q    <= rej_d;
            cout_q   <= cout_d;
            cvalid_q <= cvalid_d;
            hold_q   <= hold_d;
        end
    end

    always_comb begin
        stock_empty = '0;
        for (int k = 0; k < NUM_ITEMS; k++) stock_empty[k] = (stock_q[k] == '0);
    end

    assign credit         = credit_q;
    assign out_take       = take_q;
    assign out_less       = less_q;
    assign out_money      = money_q;
    assign out_empty      = empty_q;
    assign vend_item      = item_q;
    assign vend_pulse     = vpulse_q;
    assign coin_rej       = rej_q;
    assign coin_out       = cout_q;
    assign coin_out_valid = cvalid_q;

endmodule

// File: doc/vend_ctrl_multi.md
# vend_ctrl_multi

Parametrised vending-machine controller for NUM_ITEMS products with per-item stock tracking, run-time programmable prices, three coin denominations and coin-by-coin change dispensing over a valid/ready handshake. It sits between the debounced coin/button inputs and the seven-segment display driver: it presents running credit on `credit` and drives the take/less/money/empty indicator lamps for a fixed hold time.

## Interface
- NUM_ITEMS, 4, number of products (2..8)
- CREDIT_W, 12, credit register width (units of 0.1 yuan)
- PRICE_W, 8, width of each price field
- STOCK_W, 6, width of each stock counter
- STOCK_INIT, 15, stock loaded at reset and on `restock`
- COIN0 / COIN1 / COIN2, 5 / 10 / 50, coin values; must satisfy COIN0 < COIN1 < COIN2
- HOLD_CYCLES, 120_000_000, indicator hold time in clk cycles (3 s at 40 MHz)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- coin_in  in  3  one-cycle pulses, already debounced; bit i = coin of value COINi
- buy_req  in  NUM_ITEMS  one-cycle purchase pulses, one bit per item
- refund  in  1  one-cycle refund request pulse
- restock  in  1  one-cycle pulse: reload every stock counter to STOCK_INIT
- price_bus  in  NUM_ITEMS*PRICE_W  packed prices; item k occupies bits [k*PRICE_W +: PRICE_W]
- credit  out  CREDIT_W  current credit
- stock_empty  out  NUM_ITEMS  bit k high when stock[k]==0 (combinational from the stock registers)
- out_take / out_less / out_money / out_empty  out  1 each  indicator lamps
- vend_item  out  3  index of the last item vended
- vend_pulse  out  1  one-cycle pulse on a successful vend
- coin_rej  out  1  one-cycle pulse when an inserted coin is rejected
- coin_out  out  3  one-hot denomination of the change coin being offered
- coin_out_valid  out  1  change coin offered; held until accepted
- coin_out_ready  in  1  coin hopper accepts the offered coin

## Operation
- Reset (reset==0 at a clk edge): state IDLE, credit=0, all stock=STOCK_INIT, all lamps 0, vend_item=0, vend_pulse=0, coin_rej=0, coin_out=0, coin_out_valid=0, hold timer=0.
- Coin acceptance happens in every state except CHANGE. Per cycle, new credit = credit + sum of the values of the coins asserted on `coin_in`; several bits may be set in the same cycle. If the sum would exceed 2^CREDIT_W−1, all coins in that cycle are rejected: credit is unchanged and coin_rej pulses. Coins that arrive in CHANGE are always rejected.
- FSM states: IDLE, CHANGE, HOLD.
- IDLE, priority order refund > buy > restock:
  - Refund with credit==0: go to HOLD with out_money=1.
  - Refund with credit>0: go to CHANGE.
  - Buy: if several bits are set, the lowest index k wins.
    - stock[k]==0: go to HOLD with out_empty=1.
    - credit < price[k]: go to HOLD with out_less=1.
    - Otherwise: credit −= price[k], stock[k] −= 1, vend_item=k, vend_pulse for 1 cycle, go to HOLD with out_take=1.
  - The price check uses credit as registered before the edge. A coin arriving in the same cycle is added after the deduction.
  - Restock (only when there is no buy or refund): reload all stock counters; stay in IDLE.
- CHANGE: offer the largest COINi that is ≤ credit. On a valid&&ready edge, subtract that coin from credit and offer the next coin.
  - credit==0: drop valid, go to HOLD with out_money=1.
  - 0 < credit < COIN0: the remainder stays in credit; drop valid, go to HOLD with out_money=1.
  - buy_req and refund are ignored in CHANGE.
- HOLD: exactly one lamp is lit. buy_req, refund and restock are ignored. After HOLD_CYCLES cycles, clear all lamps and return to IDLE.
- All arithmetic is unsigned. Credit never underflows, because a deduction happens only after a successful comparison. The stock counter of an item is never decremented from 0.

## Timing
- All outputs are registered except stock_empty.
- Vend: the buy_req pulse is sampled at edge N; credit, stock, vend_pulse and out_take update at N. vend_pulse is high for cycle N..N+1 only.
- Lamp duration: the lamp rises at the edge of the decision and falls exactly HOLD_CYCLES edges later, with the state returning to IDLE at that same edge. A request that lands on that edge is ignored; requests are accepted from the following cycle.
- Change handshake: coin_out_valid rises 1 edge after refund is sampled. coin_out is held stable while valid && !ready. Each accepted coin costs ≥1 cycle. valid falls at the edge where the last coin is accepted.
- Reset mid-operation (in CHANGE or HOLD) aborts immediately. Any credit not yet paid out is lost.

## Test plan
- Set HOLD_CYCLES=8 and prices {15,25,40,5}. Insert COIN1 then COIN0 (credit 15), then buy_req[0] → vend_pulse, vend_item=0, credit=0, stock[0]=14, out_take high for 8 cycles.
- Credit 10, buy_req[1] → out_less for 8 cycles, credit stays 10, stock[1] unchanged. Pulse buy_req[0] during HOLD → no effect.
- Credit 75, refund, coin_out_ready held low for 3 cycles then high → coins offered 50, 10, 10, 5. The first coin stays stable while ready is low. credit=0, then out_money.
- Drain stock[3] to 0 with 15 buys → stock_empty[3]=1. The next buy_req[3] gives out_empty and credit unchanged. restock → stock_empty=0.
- buy_req=4'b0110 together with refund, credit 60 → the refund wins. Then with credit 60, buy_req=4'b0110 → item 1 is vended, credit 35. A coin inserted in the same cycle as a buy → credit = old − price + coin.
- Credit at 4090 with CREDIT_W=12, insert COIN1 → coin_rej, credit stays 4090. reset low during CHANGE → all outputs return to reset values on the next edge.
